// File: rtl/s32x_fb_arbiter.sv
// Single-port arbiter/sequencer for one 64Kx16 framebuffer DRAM bank shared by
// refresh, display fetch, fill, write-FIFO drain and CPU read requesters.
module s32x_fb_arbiter #(
  parameter int unsigned ACC_CYC  = 6,
  parameter int unsigned RFSH_CYC = 40,
  parameter int unsigned STARVE   = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        RFSH_REQ,
  output logic        RFSH_BUSY,
  input  logic        DISP_REQ,
  input  logic [15:0] DISP_A,
  output logic        DISP_ACK,
  output logic [15:0] DISP_Q,
  input  logic        FILL_REQ,
  input  logic [15:0] FILL_A,
  input  logic [15:0] FILL_D,
  output logic        FILL_ACK,
  input  logic        WR_REQ,
  input  logic [15:0] WR_A,
  input  logic [15:0] WR_D,
  input  logic [1:0]  WR_BE,
  output logic        WR_ACK,
  input  logic        RD_REQ,
  input  logic [15:0] RD_A,
  output logic        RD_ACK,
  output logic [15:0] RD_Q,
  output logic [15:0] FB_A,
  output logic [15:0] FB_DO,
  output logic [1:0]  FB_WE,
  output logic        FB_RD,
  input  logic [15:0] FB_DI
);

  localparam int unsigned CNT_MAX = (ACC_CYC > RFSH_CYC) ? ACC_CYC : RFSH_CYC;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam int unsigned SW      = 8;
  localparam logic [SW-1:0] STARVE_TH = SW'(STARVE);

  typedef enum logic [1:0] {IDLE, ACC, RFSH} state_t;
  typedef enum logic [1:0] {SRC_DISP, SRC_FILL, SRC_WR, SRC_RD} src_t;

  state_t        state_q, state_d;
  src_t          src_q, src_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          rfsh_pend_q, rfsh_pend_d;
  logic          busy_q, busy_d;
  logic [15:0]   fb_a_q, fb_a_d, fb_do_q, fb_do_d;
  logic [1:0]    fb_we_q, fb_we_d;
  logic          fb_rd_q, fb_rd_d;
  logic          disp_ack_q, disp_ack_d, fill_ack_q, fill_ack_d;
  logic          wr_ack_q, wr_ack_d, rd_ack_q, rd_ack_d;
  logic [15:0]   disp_q_q, disp_q_d, rd_q_q, rd_q_d;
  logic          rd_grant;
  logic          rd_starved;

  assign rd_starved = RD_REQ && (starve_q >= STARVE_TH);

  // Arbitration, access timing and refresh window sequencing
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    fb_a_d      = fb_a_q;
    fb_do_d     = fb_do_q;
    fb_we_d     = fb_we_q;
    fb_rd_d     = fb_rd_q;
    disp_ack_d  = 1'b0;
    fill_ack_d  = 1'b0;
    wr_ack_d    = 1'b0;
    rd_ack_d    = 1'b0;
    disp_q_d    = disp_q_q;
    rd_q_d      = rd_q_q;
    rd_grant    = 1'b0;
    rfsh_pend_d = rfsh_pend_q | (RFSH_REQ && (state_q != RFSH));

    case (state_q)
      IDLE: begin
        if (rfsh_pend_q) begin
          state_d     = RFSH;
          rfsh_pend_d = 1'b0;
          busy_d      = 1'b1;
          cnt_d       = CW'(RFSH_CYC - 1);
        end else if (DISP_REQ) begin
          state_d = ACC;
          src_d   = SRC_DISP;
          cnt_d   = CW'(ACC_CYC - 1);
          fb_a_d  = DISP_A;
          fb_rd_d = 1'b1;
        end else if (FILL_REQ) begin
          state_d = ACC;
          src_d   = SRC_FILL;
          cnt_d   = CW'(ACC_CYC - 1);
          fb_a_d  = FILL_A;
          fb_do_d = FILL_D;
          fb_we_d = 2'b11;
        end else if (WR_REQ && !rd_starved) begin
          state_d = ACC;
          src_d   = SRC_WR;
          cnt_d   = CW'(ACC_CYC - 1);
          fb_a_d  = WR_A;
          fb_do_d = WR_D;
          fb_we_d = WR_BE;
        end else if (RD_REQ) begin
          state_d  = ACC;
          src_d    = SRC_RD;
          cnt_d    = CW'(ACC_CYC - 1);
          fb_a_d   = RD_A;
          fb_rd_d  = 1'b1;
          rd_grant = 1'b1;
        end
      end
      ACC: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          fb_rd_d = 1'b0;
          fb_we_d = 2'b00;
          case (src_q)
            SRC_DISP: begin disp_ack_d = 1'b1; disp_q_d = FB_DI; end
            SRC_FILL: fill_ack_d = 1'b1;
            SRC_WR:   wr_ack_d   = 1'b1;
            default:  begin rd_ack_d = 1'b1; rd_q_d = FB_DI; end
          endcase
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RFSH: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A waiting read ages on every cycle it is not granted or being served
    starve_d = starve_q;
    if (rd_grant) begin
      starve_d = '0;
    end else if (RD_REQ && !((state_q == ACC) && (src_q == SRC_RD)) && (starve_q != '1)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      src_q       <= SRC_DISP;
      cnt_q       <= '0;
      starve_q    <= '0;
      rfsh_pend_q <= 1'b0;
      busy_q      <= 1'b0;
      fb_a_q      <= '0;
      fb_do_q     <= '0;
      fb_we_q     <= 2'b00;
      fb_rd_q     <= 1'b0;
      disp_ack_q  <= 1'b0;
      fill_ack_q  <= 1'b0;
      wr_ack_q    <= 1'b0;
      rd_ack_q    <= 1'b0;
      disp_q_q    <= '0;
      rd_q_q      <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      rfsh_pend_q <= rfsh_pend_d;
      busy_q      <= busy_d;
      fb_a_q      <= fb_a_d;
      fb_do_q     <= fb_do_d;
      fb_we_q     <= fb_we_d;
      fb_rd_q     <= fb_rd_d;
      disp_ack_q  <= disp_ack_d;
      fill_ack_q  <= fill_ack_d;
      wr_ack_q    <= wr_ack_d;
      rd_ack_q    <= rd_ack_d;
      disp_q_q    <= disp_q_d;
      rd_q_q      <= rd_q_d;
    end
  end

  assign RFSH_BUSY = busy_q;
  assign DISP_ACK  = disp_ack_q;
  assign DISP_Q    = disp_q_q;
  assign FILL_ACK  = fill_ack_q;
  assign WR_ACK    = wr_ack_q;
  assign RD_ACK    = rd_ack_q;
  assign RD_Q      = rd_q_q;
  assign FB_A      = fb_a_q;
  assign FB_DO     = fb_do_q;
  assign FB_WE     = fb_we_q;
  assign FB_RD     = fb_rd_q;

endmodule

// File: tb/tb_s32x_fb_arbiter.sv
// Scoreboard bench for s32x_fb_arbiter: directed requests push expected
// completions; a negedge monitor pops and checks every ACK and refresh window.
module tb_s32x_fb_arbiter;

  localparam int K_DISP = 0;
  localparam int K_FILL = 1;
  localparam int K_WR   = 2;
  localparam int K_RD   = 3;
  localparam int K_RFSH = 4;

  typedef struct {
    int          kind;
    logic [15:0] q;
    logic [15:0] a;
    logic [15:0] d;
    bit          chk_d;
    logic [1:0]  we;
    logic        rd;
    int          gap;
  } exp_t;

  logic        CLK;
  logic        RST_N;
  logic        RFSH_REQ, RFSH_BUSY;
  logic        DISP_REQ, DISP_ACK;
  logic [15:0] DISP_A, DISP_Q;
  logic        FILL_REQ, FILL_ACK;
  logic [15:0] FILL_A, FILL_D;
  logic        WR_REQ, WR_ACK;
  logic [15:0] WR_A, WR_D;
  logic [1:0]  WR_BE;
  logic        RD_REQ, RD_ACK;
  logic [15:0] RD_A, RD_Q;
  logic [15:0] FB_A, FB_DO, FB_DI;
  logic [1:0]  FB_WE;
  logic        FB_RD;

  s32x_fb_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .RFSH_REQ(RFSH_REQ), .RFSH_BUSY(RFSH_BUSY),
    .DISP_REQ(DISP_REQ), .DISP_A(DISP_A), .DISP_ACK(DISP_ACK), .DISP_Q(DISP_Q),
    .FILL_REQ(FILL_REQ), .FILL_A(FILL_A), .FILL_D(FILL_D), .FILL_ACK(FILL_ACK),
    .WR_REQ(WR_REQ), .WR_A(WR_A), .WR_D(WR_D), .WR_BE(WR_BE), .WR_ACK(WR_ACK),
    .RD_REQ(RD_REQ), .RD_A(RD_A), .RD_ACK(RD_ACK), .RD_Q(RD_Q),
    .FB_A(FB_A), .FB_DO(FB_DO), .FB_WE(FB_WE), .FB_RD(FB_RD), .FB_DI(FB_DI)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Bank model: one marked word, every other address reads back its complement
  assign FB_DI = (FB_A == 16'h0123) ? 16'hBEEF : ~FB_A;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  bit   done = 1'b0;
  bit   wr_hold = 1'b0;

  int          cyc = 0;
  int          last_ack = 0;
  int          stb = 0;
  int          busy = 0;
  int          nack = 0;
  int          k = 0;
  logic        busy_prev = 1'b0;
  logic [15:0] sa = '0;
  logic [15:0] sd = '0;
  logic [1:0]  swe = '0;
  logic        srd = 1'b0;
  exp_t        e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic void push(input int kind, input logic [15:0] q, input logic [15:0] a,
                               input logic [15:0] d, input bit chk_d, input logic [1:0] we,
                               input logic rd, input int gap);
    exp_t x;
    x.kind = kind; x.q = q; x.a = a; x.d = d; x.chk_d = chk_d;
    x.we = we; x.rd = rd; x.gap = gap;
    exp_q.push_back(x);
  endfunction

  // Monitor: owns every comparison and the summary
  initial begin
    forever begin
      @(negedge CLK);
      cyc++;
      if (done || cyc > 20000) begin
        if (!done) chk("timeout", 32'(cyc), 32'(20000));
        chk("queue_empty", 32'(exp_q.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (!RST_N) begin
        chk("rst_acks", 32'({DISP_ACK, FILL_ACK, WR_ACK, RD_ACK}), 32'(0));
        chk("rst_strobes", 32'({FB_WE, FB_RD, RFSH_BUSY}), 32'(0));
        chk("rst_addr_data", {FB_A, FB_DO}, 32'(0));
        chk("rst_qregs", {DISP_Q, RD_Q}, 32'(0));
        stb = 0; busy = 0; busy_prev = 1'b0; last_ack = cyc;
      end else begin
        if (FB_RD || (FB_WE != 2'b00)) begin
          if (stb == 0) begin sa = FB_A; sd = FB_DO; swe = FB_WE; srd = FB_RD; end
          stb++;
        end
        if (RFSH_BUSY) busy++;
        nack = int'(DISP_ACK) + int'(FILL_ACK) + int'(WR_ACK) + int'(RD_ACK);
        if (nack != 0) begin
          k = DISP_ACK ? K_DISP : FILL_ACK ? K_FILL : WR_ACK ? K_WR : K_RD;
          chk("single_ack", 32'(nack), 32'(1));
          if (exp_q.size() == 0) begin
            chk("unexpected_ack", 32'(k), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("ack_kind", 32'(k), 32'(e.kind));
            if (k == K_DISP) chk("disp_q", 32'(DISP_Q), 32'(e.q));
            if (k == K_RD)   chk("rd_q", 32'(RD_Q), 32'(e.q));
            chk("fb_a", 32'(sa), 32'(e.a));
            if (e.chk_d) chk("fb_do", 32'(sd), 32'(e.d));
            chk("fb_we", 32'(swe), 32'(e.we));
            chk("fb_rd", 32'(srd), 32'(e.rd));
            chk("strobe_cycles", 32'(stb), 32'(6));
            if (e.gap != 0) chk("ack_gap", 32'(cyc - last_ack), 32'(e.gap));
          end
          last_ack = cyc;
          stb = 0;
        end
        if (busy_prev && !RFSH_BUSY) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_rfsh", 32'(busy), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("rfsh_kind", 32'(K_RFSH), 32'(e.kind));
            chk("rfsh_busy_cycles", 32'(busy), 32'(40));
            if (e.gap != 0) chk("rfsh_gap", 32'(cyc - last_ack), 32'(e.gap));
          end
          last_ack = cyc;
          busy = 0;
        end
        busy_prev = RFSH_BUSY;
      end
    end
  end

  // One clock of requester behaviour: drop a request once its ACK is seen
  task automatic tick();
    @(negedge CLK);
    if (DISP_ACK) DISP_REQ = 1'b0;
    if (FILL_ACK) FILL_REQ = 1'b0;
    if (WR_ACK && !wr_hold) WR_REQ = 1'b0;
    if (RD_ACK) begin
      RD_REQ = 1'b0;
      if (wr_hold) begin wr_hold = 1'b0; WR_REQ = 1'b0; end
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    repeat (8) tick();
  endtask

  initial begin
    RST_N = 1'b0; RFSH_REQ = 1'b0;
    DISP_REQ = 1'b0; DISP_A = '0;
    FILL_REQ = 1'b0; FILL_A = '0; FILL_D = '0;
    WR_REQ = 1'b0; WR_A = '0; WR_D = '0; WR_BE = '0;
    RD_REQ = 1'b0; RD_A = '0;
    repeat (3) tick();
    #2 RST_N = 1'b1;
    repeat (2) tick();

    // Single display read of the marked word
    push(K_DISP, 16'hBEEF, 16'h0123, 16'h0, 1'b0, 2'b00, 1'b1, 0);
    DISP_A = 16'h0123; DISP_REQ = 1'b1;
    drain(100);

    // Four requesters at once: fixed priority, 7 cycles between ACKs
    push(K_DISP, 16'hFDFF, 16'h0200, 16'h0,    1'b0, 2'b00, 1'b1, 0);
    push(K_FILL, 16'h0,    16'h0300, 16'h1234, 1'b1, 2'b11, 1'b0, 7);
    push(K_WR,   16'h0,    16'h0400, 16'hABCD, 1'b1, 2'b10, 1'b0, 7);
    push(K_RD,   16'hFAFF, 16'h0500, 16'h0,    1'b0, 2'b00, 1'b1, 7);
    DISP_A = 16'h0200; FILL_A = 16'h0300; FILL_D = 16'h1234;
    WR_A = 16'h0400; WR_D = 16'hABCD; WR_BE = 2'b10; RD_A = 16'h0500;
    DISP_REQ = 1'b1; FILL_REQ = 1'b1; WR_REQ = 1'b1; RD_REQ = 1'b1;
    drain(200);

    // Refresh requested mid-access runs right after it; repeat pulse in window dropped
    push(K_DISP, 16'hF9FF, 16'h0600, 16'h0, 1'b0, 2'b00, 1'b1, 0);
    push(K_RFSH, 16'h0, 16'h0, 16'h0, 1'b0, 2'b00, 1'b0, 41);
    DISP_A = 16'h0600; DISP_REQ = 1'b1;
    repeat (3) tick();
    RFSH_REQ = 1'b1; tick(); RFSH_REQ = 1'b0;
    repeat (15) tick();
    RFSH_REQ = 1'b1; tick(); RFSH_REQ = 1'b0;
    drain(200);
    repeat (50) tick();

    // Back-to-back writes starve a read until its wait count reaches 32
    for (int i = 0; i < 5; i++)
      push(K_WR, 16'h0, 16'h0700, 16'h0F0F, 1'b1, 2'b11, 1'b0, (i == 0) ? 0 : 7);
    push(K_RD, 16'hF7FF, 16'h0800, 16'h0, 1'b0, 2'b00, 1'b1, 7);
    WR_A = 16'h0700; WR_D = 16'h0F0F; WR_BE = 2'b11; RD_A = 16'h0800;
    wr_hold = 1'b1; WR_REQ = 1'b1; RD_REQ = 1'b1;
    drain(300);

    // Partial byte-enable write
    push(K_WR, 16'h0, 16'h0010, 16'h55AA, 1'b1, 2'b01, 1'b0, 0);
    WR_A = 16'h0010; WR_D = 16'h55AA; WR_BE = 2'b01; WR_REQ = 1'b1;
    drain(100);

    // Reset in the middle of a write aborts it without an ACK
    WR_A = 16'h0020; WR_D = 16'h1111; WR_BE = 2'b11; WR_REQ = 1'b1;
    repeat (3) tick();
    #2 RST_N = 1'b0; WR_REQ = 1'b0;
    repeat (2) tick();
    #2 RST_N = 1'b1;
    tick();
    push(K_RD, 16'hFFCF, 16'h0030, 16'h0, 1'b0, 2'b00, 1'b1, 0);
    RD_A = 16'h0030; RD_REQ = 1'b1;
    drain(100);

    done = 1'b1;
  end

endmodule
